// File: rtl/read_buffer_controller_pkg.sv
// Shared definitions for the write-buffer handshake: responder FSM encoding,
// default geometry and handshake levels also used by the writer-side controller.
package read_buffer_controller_pkg;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_FULL  = 2'd1,
      R_READY = 2'd2
   } rstate_t;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_DEPTH  = 8;

   // Active level of write_req / write_in_buffer on both sides of the link.
   localparam logic HS_ACTIVE = 1'b1;

endpackage

// File: rtl/buffer_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// asynchronous read port, giving first-word fall-through at the head.
module buffer_fifo_mem #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage is data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/read_buffer_controller.sv
// Responder end of the write-buffer handshake: reserves one slot per write_req,
// captures the strobed word into a FIFO and presents it to a downstream reader.
module read_buffer_controller
   import read_buffer_controller_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write_req,
   input  logic              write_in_buffer,
   input  logic [DATA_W-1:0] wr_data,
   output logic              ready,
   input  logic              rd_en,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              protocol_err
);

   localparam int AW = $clog2(DEPTH);

   rstate_t           state;
   rstate_t           state_next;
   logic [AW-1:0]     head;
   logic [AW-1:0]     tail;
   logic [DATA_W-1:0] mem_data;
   logic              req;
   logic              strobe;
   logic              wr_acc;
   logic              pop;
   logic              stray;

   assign req    = (write_req == HS_ACTIVE);
   assign strobe = (write_in_buffer == HS_ACTIVE);

   assign full     = (count == CNT_W'(DEPTH));
   assign rd_valid = (count != '0);
   assign ready    = (state == R_READY);

   // A slot is only ever reserved while space exists, and nothing but this
   // port can fill it, so an accepted strobe never needs a full check.
   assign wr_acc = strobe && (state == R_READY);
   assign stray  = strobe && (state != R_READY);
   assign pop    = rd_en && rd_valid;

   always_comb begin
      state_next = state;
      case (state)
         R_IDLE: begin
            if (req) state_next = full ? R_FULL : R_READY;
         end
         R_FULL: begin
            if (!req)       state_next = R_IDLE;
            else if (!full) state_next = R_READY;
         end
         R_READY: begin
            if (strobe || !req) state_next = R_IDLE;
         end
         default: state_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= R_IDLE;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         protocol_err <= 1'b0;
      end else begin
         state <= state_next;
         if (wr_acc) tail <= tail + AW'(1);
         if (pop)    head <= head + AW'(1);
         case ({wr_acc, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (stray) protocol_err <= 1'b1;
      end
   end

   buffer_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (tail),
      .wr_data (wr_data),
      .rd_addr (head),
      .rd_data (mem_data)
   );

   // Stale storage is hidden while empty so rd_data reads zero out of reset.
   assign rd_data = rd_valid ? mem_data : '0;

endmodule

// File: tb/tb_read_buffer_controller.sv
// Self-checking bench for read_buffer_controller: directed scenarios plus a
// randomized phase, all scored against a queue-based reservation model.
module tb_read_buffer_controller;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk;
   logic              rst;
   logic              write_req;
   logic              write_in_buffer;
   logic [DATA_W-1:0] wr_data;
   logic              ready;
   logic              rd_en;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              protocol_err;

   read_buffer_controller #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .write_req       (write_req),
      .write_in_buffer (write_in_buffer),
      .wr_data         (wr_data),
      .ready           (ready),
      .rd_en           (rd_en),
      .rd_valid        (rd_valid),
      .rd_data         (rd_data),
      .count           (count),
      .full            (full),
      .protocol_err    (protocol_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: stored words in order, whether a slot is granted,
   // whether the writer is parked waiting for space, and the sticky error.
   logic [DATA_W-1:0] q[$];
   bit m_grant;
   bit m_wait;
   bit m_err;

   logic [DATA_W-1:0] popped[$];
   bit rand_rd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [DATA_W-1:0] exp_head;
      exp_head = (q.size() > 0) ? q[0] : '0;
      chk({tag, ".ready"},    32'(ready),        32'(m_grant));
      chk({tag, ".rd_valid"}, 32'(rd_valid),     32'(q.size() > 0));
      chk({tag, ".rd_data"},  32'(rd_data),      32'(exp_head));
      chk({tag, ".count"},    32'(count),        32'(q.size()));
      chk({tag, ".full"},     32'(full),         32'(q.size() == DEPTH));
      chk({tag, ".perr"},     32'(protocol_err), 32'(m_err));
   endtask

   // Advance one clock: derive the model's next contents from the inputs
   // presented before the edge, then compare after the edge.
   task automatic step(input string tag);
      bit acc, do_pop, n_grant, n_wait;
      int sz;
      sz     = q.size();
      acc    = m_grant && write_in_buffer;
      do_pop = rd_en && (sz > 0);
      if (m_grant) begin
         n_grant = write_req && !write_in_buffer;
         n_wait  = 1'b0;
      end else if (m_wait) begin
         n_grant = write_req && (sz < DEPTH);
         n_wait  = write_req && (sz == DEPTH);
      end else begin
         n_grant = write_req && (sz < DEPTH);
         n_wait  = write_req && (sz == DEPTH);
      end
      if (do_pop) popped.push_back(rd_data);
      @(posedge clk);
      #1;
      if (write_in_buffer && !m_grant) m_err = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (acc) q.push_back(wr_data);
      m_grant = n_grant;
      m_wait  = n_wait;
      check_all(tag);
   endtask

   task automatic model_clear();
      q.delete();
      m_grant = 1'b0;
      m_wait  = 1'b0;
      m_err   = 1'b0;
   endtask

   // Asynchronous assertion is checked before any clock edge arrives.
   task automatic do_reset(input string tag);
      write_req       = 1'b0;
      write_in_buffer = 1'b0;
      rd_en           = 1'b0;
      rst             = 1'b0;
      #2;
      model_clear();
      chk({tag, ".rst_ready"},    32'(ready),        32'd0);
      chk({tag, ".rst_rd_valid"}, 32'(rd_valid),     32'd0);
      chk({tag, ".rst_full"},     32'(full),         32'd0);
      chk({tag, ".rst_perr"},     32'(protocol_err), 32'd0);
      chk({tag, ".rst_rd_data"},  32'(rd_data),      32'd0);
      chk({tag, ".rst_count"},    32'(count),        32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Writer-side transaction: request, wait for the grant, strobe once.
   task automatic write_word(input logic [DATA_W-1:0] w, input string tag);
      int guard;
      guard     = 0;
      write_req = 1'b1;
      while (!ready && guard < 40) begin
         if (rand_rd) rd_en = 1'($urandom_range(0, 1));
         step({tag, ".req"});
         guard++;
      end
      if (!ready) chk({tag, ".grant_timeout"}, 32'(ready), 32'd1);
      write_req       = 1'b0;
      write_in_buffer = 1'b1;
      wr_data         = w;
      if (rand_rd) rd_en = 1'($urandom_range(0, 1));
      step({tag, ".strobe"});
      write_in_buffer = 1'b0;
      rd_en           = 1'b0;
   endtask

   initial begin
      rst             = 1'b0;
      write_req       = 1'b0;
      write_in_buffer = 1'b0;
      wr_data         = '0;
      rd_en           = 1'b0;
      rand_rd         = 1'b0;
      model_clear();
      #1;
      do_reset("init");

      // Basic grant latency and first-word fall-through.
      write_req = 1'b1;
      step("t1.req");
      chk("t1.ready_one_cycle", 32'(ready), 32'd1);
      write_req       = 1'b0;
      write_in_buffer = 1'b1;
      wr_data         = 16'h00A5;
      step("t1.strobe");
      write_in_buffer = 1'b0;
      chk("t1.rd_valid", 32'(rd_valid), 32'd1);
      chk("t1.rd_data",  32'(rd_data),  32'h00A5);
      chk("t1.count",    32'(count),    32'd1);

      // Fill, stall in the full wait, then release by a single pop.
      for (int i = 1; i < DEPTH; i++) write_word(DATA_W'(i), "t2.fill");
      chk("t2.count_full", 32'(count), 32'(DEPTH));
      chk("t2.full",       32'(full),  32'd1);
      write_req = 1'b1;
      step("t2.wait0");
      step("t2.wait1");
      chk("t2.no_ready_when_full", 32'(ready), 32'd0);
      rd_en = 1'b1;
      step("t2.pop");
      rd_en = 1'b0;
      chk("t2.full_drops", 32'(full),  32'd0);
      chk("t2.ready_late", 32'(ready), 32'd0);
      step("t2.release");
      chk("t2.ready_after", 32'(ready), 32'd1);
      write_req       = 1'b0;
      write_in_buffer = 1'b1;
      wr_data         = 16'h0BEE;
      step("t2.strobe");
      write_in_buffer = 1'b0;
      chk("t2.count_refill", 32'(count), 32'(DEPTH));

      // Simultaneous write and pop at count==1.
      do_reset("t3");
      write_word(16'h0001, "t3.w1");
      write_req = 1'b1;
      step("t3.req");
      write_req       = 1'b0;
      write_in_buffer = 1'b1;
      wr_data         = 16'h0002;
      rd_en           = 1'b1;
      step("t3.both");
      write_in_buffer = 1'b0;
      rd_en           = 1'b0;
      chk("t3.count_same", 32'(count),   32'd1);
      chk("t3.head_new",   32'(rd_data), 32'h0002);

      // Twenty words with random interleaved pops across pointer wrap.
      do_reset("t4");
      popped.delete();
      rand_rd = 1'b1;
      for (int i = 0; i < 20; i++) write_word(DATA_W'(i), "t4.w");
      rand_rd = 1'b0;
      rd_en   = 1'b1;
      for (int i = 0; i < 2 * DEPTH && rd_valid; i++) step("t4.drain");
      rd_en = 1'b0;
      chk("t4.popped_len", 32'(popped.size()), 32'd20);
      for (int i = 0; i < popped.size() && i < 20; i++)
         chk($sformatf("t4.order%0d", i), 32'(popped[i]), 32'(i));

      // Strobe without a grant is discarded and flagged until reset.
      write_in_buffer = 1'b1;
      wr_data         = 16'hDEAD;
      step("t5.stray");
      write_in_buffer = 1'b0;
      chk("t5.perr",  32'(protocol_err), 32'd1);
      chk("t5.count", 32'(count),        32'd0);
      write_word(16'h0055, "t5.after");
      chk("t5.perr_sticky", 32'(protocol_err), 32'd1);

      // Reset mid-reservation with three stored words.
      do_reset("t6a");
      for (int i = 0; i < 3; i++) write_word(DATA_W'(16'h30 + i), "t6.w");
      write_req = 1'b1;
      step("t6.req");
      chk("t6.in_ready", 32'(ready), 32'd1);
      do_reset("t6");

      // Strobe coincident with the first clock after reset release.
      write_in_buffer = 1'b1;
      wr_data         = 16'h7777;
      step("t7.strobe_at_release");
      write_in_buffer = 1'b0;

      // Randomized writer and reader against the model.
      do_reset("t8");
      for (int c = 0; c < 400; c++) begin
         if (ready) begin
            write_in_buffer = ($urandom_range(0, 9) < 7);
            write_req       = write_in_buffer ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) != 0);
         end else begin
            write_in_buffer = ($urandom_range(0, 49) == 0);
            write_req       = ($urandom_range(0, 9) < 8);
         end
         wr_data = DATA_W'($urandom);
         rd_en   = 1'($urandom_range(0, 1));
         step("rnd");
      end
      write_req       = 1'b0;
      write_in_buffer = 1'b0;
      rd_en           = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
